// File: rtl/eth_phy_10g_rx_block_lock.sv
// 10GBASE-R receive block-lock and high-BER supervisor.
// It watches each 66b sync header, hunts for alignment with SERDES bitslip, and flags excess header errors.
module eth_phy_10g_rx_block_lock #(
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  input  logic [1:0] serdes_rx_hdr,
  output logic       serdes_rx_bitslip,
  output logic       rx_block_lock,
  output logic       rx_high_ber
);

  localparam int TIME_W   = $clog2(COUNT_125US + 1);
  localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                            BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int SLIP_W   = (SLIP_MAX > 1) ? $clog2(SLIP_MAX) : 1;

  localparam logic [TIME_W-1:0] TIME_RELOAD = TIME_W'(COUNT_125US);
  localparam logic [TIME_W-1:0] TIME_ONE    = TIME_W'(1);
  localparam logic [SLIP_W-1:0] HIGH_LOAD   = SLIP_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [SLIP_W-1:0] LOW_LOAD    = SLIP_W'(BITSLIP_LOW_CYCLES - 1);
  localparam logic [SLIP_W-1:0] SLIP_ONE    = SLIP_W'(1);

  typedef enum logic [1:0] {
    SLIP_IDLE = 2'd0,
    SLIP_HIGH = 2'd1,
    SLIP_LOW  = 2'd2
  } slip_phase_t;

  slip_phase_t       slip_phase_q, slip_phase_d;
  logic [SLIP_W-1:0] slip_count_q, slip_count_d;
  logic [5:0]        sh_count_q, sh_count_d;
  logic [3:0]        sh_invalid_count_q, sh_invalid_count_d;
  logic              lock_q, lock_d;
  logic              bitslip_q, bitslip_d;
  logic [3:0]        ber_count_q, ber_count_d;
  logic [TIME_W-1:0] time_count_q, time_count_d;
  logic              high_ber_q, high_ber_d;
  logic              hdr_valid;

  assign hdr_valid = serdes_rx_hdr[1] ^ serdes_rx_hdr[0];

  // Frame sync and slip sequencing; headers are only evaluated while no slip is in flight.
  always_comb begin
    slip_phase_d       = slip_phase_q;
    slip_count_d       = slip_count_q;
    sh_count_d         = sh_count_q;
    sh_invalid_count_d = sh_invalid_count_q;
    lock_d             = lock_q;
    bitslip_d          = 1'b0;
    case (slip_phase_q)
      SLIP_IDLE: begin
        if (hdr_valid) begin
          if (sh_count_q == 6'd63) begin
            sh_count_d         = 6'd0;
            sh_invalid_count_d = 4'd0;
            if (sh_invalid_count_q == 4'd0) begin
              lock_d = 1'b1;
            end else begin
              lock_d = lock_q;
            end
          end else begin
            sh_count_d = sh_count_q + 6'd1;
          end
        end else if (!lock_q || (sh_invalid_count_q == 4'd15)) begin
          sh_count_d         = 6'd0;
          sh_invalid_count_d = 4'd0;
          lock_d             = 1'b0;
          slip_phase_d       = SLIP_HIGH;
          slip_count_d       = HIGH_LOAD;
          bitslip_d          = 1'b1;
        end else if (sh_count_q == 6'd63) begin
          sh_count_d         = 6'd0;
          sh_invalid_count_d = 4'd0;
        end else begin
          sh_count_d         = sh_count_q + 6'd1;
          sh_invalid_count_d = sh_invalid_count_q + 4'd1;
        end
      end
      SLIP_HIGH: begin
        if (slip_count_q == '0) begin
          if (BITSLIP_LOW_CYCLES == 0) begin
            slip_phase_d = SLIP_IDLE;
          end else begin
            slip_phase_d = SLIP_LOW;
            slip_count_d = LOW_LOAD;
          end
        end else begin
          slip_count_d = slip_count_q - SLIP_ONE;
          bitslip_d    = 1'b1;
        end
      end
      SLIP_LOW: begin
        if (slip_count_q == '0) begin
          slip_phase_d = SLIP_IDLE;
        end else begin
          slip_count_d = slip_count_q - SLIP_ONE;
        end
      end
      default: begin
        slip_phase_d = SLIP_IDLE;
      end
    endcase
  end

  // BER window: free-running 125 us timer; expiry clears high_ber unless the 16th error lands on it.
  always_comb begin
    ber_count_d  = ber_count_q;
    high_ber_d   = high_ber_q;
    time_count_d = time_count_q;
    if (time_count_q == '0) begin
      time_count_d = TIME_RELOAD;
      ber_count_d  = 4'd0;
      high_ber_d   = !hdr_valid && (ber_count_q == 4'd15);
    end else begin
      time_count_d = time_count_q - TIME_ONE;
      if (!hdr_valid) begin
        if (ber_count_q == 4'd15) begin
          high_ber_d = 1'b1;
        end else begin
          ber_count_d = ber_count_q + 4'd1;
        end
      end else begin
        ber_count_d = ber_count_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      slip_phase_q       <= SLIP_IDLE;
      slip_count_q       <= '0;
      sh_count_q         <= 6'd0;
      sh_invalid_count_q <= 4'd0;
      lock_q             <= 1'b0;
      bitslip_q          <= 1'b0;
      ber_count_q        <= 4'd0;
      time_count_q       <= TIME_RELOAD;
      high_ber_q         <= 1'b0;
    end else begin
      slip_phase_q       <= slip_phase_d;
      slip_count_q       <= slip_count_d;
      sh_count_q         <= sh_count_d;
      sh_invalid_count_q <= sh_invalid_count_d;
      lock_q             <= lock_d;
      bitslip_q          <= bitslip_d;
      ber_count_q        <= ber_count_d;
      time_count_q       <= time_count_d;
      high_ber_q         <= high_ber_d;
    end
  end

  assign serdes_rx_bitslip = bitslip_q;
  assign rx_block_lock     = lock_q;
  assign rx_high_ber       = high_ber_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock.sv
// Directed bench: stimulus pushes hand-derived expectations per clock, a monitor pops and compares.
// Expectation bits are {lock, bitslip, high_ber}; the mask selects which bits are checked.
module tb_eth_phy_10g_rx_block_lock;

  logic       clk;
  logic       rx_rst;
  logic [1:0] hdr;
  logic       bitslip;
  logic       lock;
  logic       ber;

  typedef struct {
    logic [2:0] exp;
    logic [2:0] mask;
    int         ph;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  eth_phy_10g_rx_block_lock #(
    .BITSLIP_HIGH_CYCLES(1),
    .BITSLIP_LOW_CYCLES (8),
    .COUNT_125US        (125)
  ) dut (
    .rx_clk           (clk),
    .rx_rst           (rx_rst),
    .serdes_rx_hdr    (hdr),
    .serdes_rx_bitslip(bitslip),
    .rx_block_lock    (lock),
    .rx_high_ber      (ber)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic [1:0] h, input logic r, input logic l, input logic s,
                      input logic b, input logic [2:0] m, input int ph, input int c);
    exp_t e;
    @(negedge clk);
    rx_rst = r;
    hdr    = h;
    e.exp  = {l, s, b};
    e.mask = m;
    e.ph   = ph;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t       e;
    logic [2:0] got;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {lock, bitslip, ber};
        for (int b = 0; b < 3; b++) begin
          if (e.mask[b]) begin
            n_cmp++;
            if (got[b] !== e.exp[b]) begin
              n_fail++;
              nm = (b == 2) ? "lock" : ((b == 1) ? "bitslip" : "high_ber");
              $display("FAIL %s phase=%0d cycle=%0d got=%b expected=%b",
                       nm, e.ph, e.cyc, got[b], e.exp[b]);
            end
          end
        end
      end
    end
  end

  initial begin
    rx_rst = 1'b1;
    hdr    = 2'b10;

    // Phase 1: reset, then 64 valid headers acquire lock.
    for (int i = 1; i <= 10; i++) step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1, i);
    for (int i = 1; i <= 64; i++) step(2'b10, 1'b0, (i == 64), 1'b0, 1'b0, 3'b111, 1, i);

    // Phase 2: alternating valid headers hold lock.
    for (int i = 65; i <= 264; i++)
      step((i % 2 == 1) ? 2'b01 : 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 2, i);

    // Phase 3: 15 invalids within a window are tolerated.
    for (int i = 265; i <= 279; i++) step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3, i);
    for (int i = 280; i <= 384; i++) step(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3, i);

    // Phase 4: 16 invalids drop lock, slip, and set high_ber; extra headers during slip are ignored.
    for (int i = 385; i <= 400; i++)
      step(2'b00, 1'b0, (i < 400), (i == 400), (i == 400), 3'b111, 4, i);
    for (int i = 401; i <= 408; i++) step(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 4, i);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 4, 409);

    // Phase 5: re-lock after hold-off; high_ber clears at the window expiry.
    for (int i = 410; i <= 510; i++)
      step(2'b10, 1'b0, (i >= 473), 1'b0, (i < 504), 3'b111, 5, i);

    // Phase 6: fresh start, 63 valid then one invalid header before lock.
    for (int i = 1; i <= 3; i++) step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 6, i);
    for (int j = 1; j <= 63; j++) step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 6, j);
    step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 6, 64);
    for (int j = 65; j <= 73; j++) step(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 6, j);
    for (int j = 74; j <= 140; j++) step(2'b10, 1'b0, (j >= 137), 1'b0, 1'b0, 3'b111, 6, j);

    // Phase 7: reset in the middle of a slip drops bitslip at once.
    for (int i = 1; i <= 2; i++) step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 7, i);
    step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 7, 3);
    step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 7, 4);
    step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 7, 5);

    // Phase 8: BER window, expiry clear, and 16th error coinciding with expiry.
    for (int k = 1; k <= 16; k++)
      step(2'b11, 1'b0, 1'b0, (k == 1 || k == 11), (k == 16), 3'b111, 8, k);
    for (int k = 17; k <= 126; k++)
      step(2'b10, 1'b0, (k >= 84), 1'b0, (k < 126), 3'b111, 8, k);
    for (int k = 127; k <= 236; k++) step(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 8, k);
    for (int k = 237; k <= 252; k++)
      step(2'b00, 1'b0, (k < 252), (k == 252), (k == 252), 3'b111, 8, k);
    for (int k = 253; k <= 260; k++) step(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 8, k);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
